// File: rtl/hdmi_i2c_config_pkg.sv
// Shared types and the ADV7513 init table for the HDMI I2C configurator.
package hdmi_i2c_config_pkg;

    typedef enum logic [3:0] {
        POWERUP,
        IDLE_GAP,
        START,
        SEND_BYTE,
        ACK,
        STOP,
        NEXT,
        DONE,
        ERROR
    } state_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } entry_t;

    localparam int N = 12;
    localparam int IDX_W = $clog2(N + 1);

    function automatic entry_t init_entry(input logic [IDX_W-1:0] i);
        entry_t e;
        case (i)
            4'd0:    e = '{8'h41, 8'h10};
            4'd1:    e = '{8'h98, 8'h03};
            4'd2:    e = '{8'h9A, 8'hE0};
            4'd3:    e = '{8'h9C, 8'h30};
            4'd4:    e = '{8'h9D, 8'h61};
            4'd5:    e = '{8'hA2, 8'hA4};
            4'd6:    e = '{8'hA3, 8'hA4};
            4'd7:    e = '{8'hE0, 8'hD0};
            4'd8:    e = '{8'hF9, 8'h00};
            4'd9:    e = '{8'h15, 8'h00};
            4'd10:   e = '{8'h16, 8'h30};
            4'd11:   e = '{8'hAF, 8'h04};
            default: e = '{8'h00, 8'h00};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Combinational lookup of one init-table entry by index.
module hdmi_cfg_rom
    import hdmi_i2c_config_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    output entry_t           entry
);

    always_comb begin
        entry = init_entry(index);
    end

endmodule

// File: rtl/hdmi_i2c_config.sv
// Open-drain I2C master that writes the ADV7513 init table after power-up,
// retries NACKed entries and rewrites the table on a hot-plug interrupt.
module hdmi_i2c_config #(
    parameter int         CLK_DIV        = 62,
    parameter int         POWERUP_CYCLES = 2500000,
    parameter logic [7:0] DEV_ADDR       = 8'h72,
    parameter int         MAX_RETRY      = 3
) (
    input  logic CLK_25MHZ,
    input  logic RESET,
    output logic I2C_SCL_OE,
    output logic I2C_SDA_OE,
    input  logic I2C_SDA_IN,
    input  logic HDMI_TX_INT,
    output logic CONFIG_DONE,
    output logic CONFIG_ERROR
);
    import hdmi_i2c_config_pkg::*;

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW = (POWERUP_CYCLES > 0) ? $clog2(POWERUP_CYCLES + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int PU_LAST = (POWERUP_CYCLES > 0) ? POWERUP_CYCLES - 1 : 0;

    state_t           state, state_n;
    logic [TW-1:0]    tick_cnt;
    logic [1:0]       phase;
    logic [2:0]       bit_cnt, bit_n;
    logic [1:0]       byte_sel, byte_n;
    logic [IDX_W-1:0] idx, idx_n, idx_inc;
    logic [RW-1:0]    retry, retry_n;
    logic [PW-1:0]    pwr_cnt;
    logic             failed, failed_n;
    logic             nack;
    logic             int_s1, int_s2, int_s3;
    logic             tick, bit_end, int_fall;
    logic             scl_oe, sda_oe;
    logic [7:0]       cur_byte;
    entry_t           entry;

    hdmi_cfg_rom u_rom (
        .index(idx),
        .entry(entry)
    );

    assign tick     = (tick_cnt == TW'(CLK_DIV - 1));
    assign bit_end  = tick && (phase == 2'd3);
    assign int_fall = int_s3 && !int_s2;
    assign idx_inc  = idx + 1'b1;

    always_comb begin
        unique case (byte_sel)
            2'd0:    cur_byte = DEV_ADDR;
            2'd1:    cur_byte = entry.reg_addr;
            default: cur_byte = entry.data;
        endcase
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            state    <= POWERUP;
            tick_cnt <= '0;
            phase    <= '0;
            bit_cnt  <= '0;
            byte_sel <= '0;
            idx      <= '0;
            retry    <= '0;
            pwr_cnt  <= '0;
            failed   <= 1'b0;
            nack     <= 1'b0;
            int_s1   <= 1'b1;
            int_s2   <= 1'b1;
            int_s3   <= 1'b1;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_n;
            byte_sel <= byte_n;
            idx      <= idx_n;
            retry    <= retry_n;
            failed   <= failed_n;
            int_s1   <= HDMI_TX_INT;
            int_s2   <= int_s1;
            int_s3   <= int_s2;
            // Each state starts on a fresh bit period
            if (state_n != state || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (state_n != state) begin
                phase <= '0;
            end else if (tick) begin
                phase <= phase + 1'b1;
            end
            if (state == POWERUP) begin
                pwr_cnt <= pwr_cnt + 1'b1;
            end
            if (state == ACK && tick && phase == 2'd2) begin
                nack <= I2C_SDA_IN;
            end
        end
    end

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        byte_n   = byte_sel;
        idx_n    = idx;
        retry_n  = retry;
        failed_n = failed;
        unique case (state)
            POWERUP: begin
                if (pwr_cnt == PW'(PU_LAST)) begin
                    state_n  = START;
                    bit_n    = 3'd7;
                    byte_n   = '0;
                    failed_n = 1'b0;
                end
            end
            IDLE_GAP: begin
                if (bit_end) begin
                    state_n  = START;
                    bit_n    = 3'd7;
                    byte_n   = '0;
                    failed_n = 1'b0;
                end
            end
            START: begin
                if (bit_end) state_n = SEND_BYTE;
            end
            SEND_BYTE: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd0) state_n = ACK;
                    else bit_n = bit_cnt - 1'b1;
                end
            end
            ACK: begin
                if (bit_end) begin
                    if (nack) begin
                        state_n  = STOP;
                        failed_n = 1'b1;
                    end else if (byte_sel == 2'd2) begin
                        state_n = STOP;
                    end else begin
                        state_n = SEND_BYTE;
                        byte_n  = byte_sel + 1'b1;
                        bit_n   = 3'd7;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!failed) begin
                        state_n = NEXT;
                    end else if (retry == RW'(MAX_RETRY)) begin
                        state_n = ERROR;
                    end else begin
                        state_n = IDLE_GAP;
                        retry_n = retry + 1'b1;
                    end
                end
            end
            NEXT: begin
                idx_n   = idx_inc;
                retry_n = '0;
                state_n = (idx_inc == IDX_W'(N)) ? DONE : IDLE_GAP;
            end
            DONE: begin
                // Hot-plug wipes the transmitter, so rewrite everything
                if (int_fall) begin
                    state_n = IDLE_GAP;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            ERROR: ;
            default: state_n = POWERUP;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        unique case (state)
            START: begin
                sda_oe = 1'b1;
                scl_oe = (phase == 2'd3);
            end
            SEND_BYTE: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
                sda_oe = ~cur_byte[bit_cnt];
            end
            ACK: begin
                scl_oe = (phase == 2'd0) || (phase == 2'd3);
            end
            STOP: begin
                scl_oe = (phase == 2'd0);
                sda_oe = ~phase[1];
            end
            default: ;
        endcase
    end

    assign I2C_SCL_OE   = scl_oe;
    assign I2C_SDA_OE   = sda_oe;
    assign CONFIG_DONE  = (state == DONE);
    assign CONFIG_ERROR = (state == ERROR);

endmodule

// File: tb/tb_hdmi_i2c_config.sv
// Bench for hdmi_i2c_config: bus-level slave model decodes each transaction
// and compares it against a hand-written table of expected writes.
module tb_hdmi_i2c_config;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_int = 1'b1;
    logic scl_oe, sda_oe, done, err;
    logic slave_oe = 1'b0;
    logic sda_line;

    assign sda_line = ~(sda_oe | slave_oe);

    always #5 clk = ~clk;

    hdmi_i2c_config #(
        .CLK_DIV(4),
        .POWERUP_CYCLES(16)
    ) dut (
        .CLK_25MHZ(clk),
        .RESET(rst),
        .I2C_SCL_OE(scl_oe),
        .I2C_SDA_OE(sda_oe),
        .I2C_SDA_IN(sda_line),
        .HDMI_TX_INT(tx_int),
        .CONFIG_DONE(done),
        .CONFIG_ERROR(err)
    );

    typedef struct {
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        bit         nack;
    } xfer_t;

    typedef struct {
        int         idx;
        logic [7:0] ra;
        logic [7:0] rd;
    } vec_t;

    xfer_t xq[$];
    xfer_t cur;
    vec_t  vec[12];

    int checks = 0;
    int errors = 0;

    int bit_cnt = 0, byte_cnt = 0;
    int nack_mode = 0, nack_left = 0;
    logic [7:0] shreg = '0;
    bit in_xfer = 0;
    logic scl_q = 1'b1, sda_q = 1'b1;
    logic b_scl, b_sda;
    bit do_nack;

    // Slave model, evaluated away from the DUT's active edge
    always @(negedge clk) begin
        b_scl = ~scl_oe;
        b_sda = ~(sda_oe | slave_oe);
        if (rst) begin
            in_xfer  = 0;
            slave_oe = 1'b0;
        end else if (b_scl && scl_q && sda_q && !b_sda) begin
            in_xfer  = 1;
            bit_cnt  = 0;
            byte_cnt = 0;
            cur      = '{0, 8'h00, 8'h00, 8'h00, 1'b0};
        end else if (in_xfer && b_scl && scl_q && !sda_q && b_sda) begin
            in_xfer = 0;
            xq.push_back(cur);
        end else if (in_xfer && b_scl && !scl_q) begin
            if (bit_cnt < 8) shreg = {shreg[6:0], b_sda};
            bit_cnt++;
        end else if (in_xfer && !b_scl && scl_q) begin
            if (bit_cnt == 8) begin
                case (byte_cnt)
                    0: cur.b0 = shreg;
                    1: cur.b1 = shreg;
                    default: cur.b2 = shreg;
                endcase
                cur.nbytes++;
                do_nack = 0;
                if (nack_mode == 1 && byte_cnt == 2 && cur.b1 == 8'h9C
                    && nack_left > 0) begin
                    do_nack = 1;
                    nack_left--;
                end
                if (nack_mode == 2 && byte_cnt == 0) do_nack = 1;
                if (do_nack) cur.nack = 1;
                slave_oe = !do_nack;
            end else if (bit_cnt == 9) begin
                slave_oe = 1'b0;
                bit_cnt  = 0;
                byte_cnt++;
            end
        end
        scl_q = b_scl;
        sda_q = b_sda;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input xfer_t x);
        return {x.nack, 7'(x.nbytes), x.b0, x.b1, x.b2};
    endfunction

    function automatic logic [31:0] good(input int e);
        return {1'b0, 7'd3, 8'h72, vec[e].ra, vec[e].rd};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, scl_oe, sda_oe, done, err}, 32'd0);
        xq.delete();
        rst = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!done && !err && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, n >= 20000}, 32'd0);
    endtask

    task automatic check_table(input string name);
        check({name, "_count"}, xq.size(), 12);
        for (int i = 0; i < 12 && i < xq.size(); i++) begin
            check($sformatf("%s_xfer%0d", name, vec[i].idx),
                  pk(xq[i]), good(i));
        end
        check({name, "_done"}, {28'd0, done, err, scl_oe, sda_oe},
              32'b1000);
    endtask

    initial begin
        int n, m;
        vec = '{
            '{0, 8'h41, 8'h10}, '{1, 8'h98, 8'h03},
            '{2, 8'h9A, 8'hE0}, '{3, 8'h9C, 8'h30},
            '{4, 8'h9D, 8'h61}, '{5, 8'hA2, 8'hA4},
            '{6, 8'hA3, 8'hA4}, '{7, 8'hE0, 8'hD0},
            '{8, 8'hF9, 8'h00}, '{9, 8'h15, 8'h00},
            '{10, 8'h16, 8'h30}, '{11, 8'hAF, 8'h04}
        };

        // Always-ACK run; an interrupt pulse mid-run must be ignored
        nack_mode = 0;
        do_reset();
        repeat (300) @(negedge clk);
        tx_int = 1'b0;
        @(negedge clk);
        tx_int = 1'b1;
        wait_end("ack_wait");
        check_table("ack");

        // Hot-plug from DONE rewrites the table without the power-up wait
        xq.delete();
        @(negedge clk);
        tx_int = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (n == 1) tx_int = 1'b1;
            if (!done) break;
        end
        check("hotplug_done_fall", {31'd0, n <= 4}, 32'd1);
        m = 0;
        while (!sda_oe && m < 100) begin
            @(negedge clk);
            m++;
        end
        check("hotplug_start_delay", m, 16);
        wait_end("hotplug_wait");
        check_table("hotplug");

        // Data byte of entry 3 NACKed once
        nack_mode = 1;
        nack_left = 1;
        do_reset();
        wait_end("retry_wait");
        check("retry_count", xq.size(), 13);
        for (int i = 0; i < 13 && i < xq.size(); i++) begin
            if (i == 3) begin
                check("retry_nacked", pk(xq[i]),
                      {1'b1, 7'd3, 8'h72, 8'h9C, 8'h30});
            end else begin
                check($sformatf("retry_xfer%0d", i), pk(xq[i]),
                      good(i < 3 ? i : i - 1));
            end
        end
        check("retry_done", {30'd0, done, err}, 32'b10);

        // Address byte always NACKed: four attempts then ERROR
        nack_mode = 2;
        do_reset();
        wait_end("error_wait");
        check("error_flags", {30'd0, done, err}, 32'b01);
        check("error_attempts", xq.size(), 4);
        for (int i = 0; i < 4 && i < xq.size(); i++) begin
            check($sformatf("error_xfer%0d", i), pk(xq[i]),
                  {1'b1, 7'd1, 8'h72, 8'h00, 8'h00});
        end
        repeat (300) @(negedge clk);
        check("error_idle",
              {26'd0, 6'(xq.size()), scl_oe, sda_oe, done, err},
              {26'd0, 6'd4, 4'b0001});

        // Reset during bit 5 of entry 2
        nack_mode = 0;
        do_reset();
        n = 0;
        while (!(xq.size() == 2 && in_xfer && byte_cnt == 0
                 && bit_cnt == 5) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("midreset_reach", {31'd0, n >= 5000}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_release", {30'd0, scl_oe, sda_oe}, 32'd0);
        repeat (3) @(negedge clk);
        xq.delete();
        rst = 1'b0;
        n = 0;
        while (!sda_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midreset_start_delay", n, 16);
        check("midreset_start_scl", {31'd0, scl_oe}, 32'd0);
        wait_end("midreset_wait");
        check_table("midreset");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

endmodule

// File: doc/hdmi_i2c_config.md
HDMI_I2C_CONFIG -- requirements
Module: hdmi_i2c_config

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter CLK_DIV, default 62, SHALL set the number of clock cycles per I2C quarter-bit tick (about 100 kHz SCL at 25 MHz).
REQ-003 Parameter POWERUP_CYCLES, default 2500000, SHALL set the wait after reset before the first transaction (100 ms).
REQ-004 Parameter DEV_ADDR, default 8'h72, SHALL be the ADV7513 8-bit write address.
REQ-005 Parameter MAX_RETRY, default 3, SHALL be the number of retries per entry after a NACK.
REQ-006 Port CLK_25MHZ, input, 1 bit: system clock.
REQ-007 Port RESET, input, 1 bit: synchronous active-high reset.
REQ-008 Port I2C_SCL_OE, output, 1 bit: 1 = pull SCL low; 0 = release SCL.
REQ-009 Port I2C_SDA_OE, output, 1 bit: 1 = pull SDA low; 0 = release SDA.
REQ-010 Port I2C_SDA_IN, input, 1 bit: sampled SDA pad level.
REQ-011 Port HDMI_TX_INT, input, 1 bit: ADV7513 interrupt, active-low.
REQ-012 Port CONFIG_DONE, output, 1 bit: 1 = all table entries written successfully.
REQ-013 Port CONFIG_ERROR, output, 1 bit: 1 = an entry failed after all retries.

Function
REQ-014 After reset, the block SHALL count POWERUP_CYCLES cycles, then write table entries 0..N-1 in order.
REQ-015 Each write SHALL be one complete transaction: START, DEV_ADDR, ACK, register address, ACK, data, ACK, STOP.
REQ-016 Bytes SHALL be sent MSB first.
REQ-017 A tick SHALL occur every CLK_DIV cycles, and each bit SHALL last 4 ticks:
- phase 0: SCL low, SDA updated;
- phase 1: SCL released;
- phase 2: SDA sampled;
- phase 3: SCL pulled low.
REQ-018 START SHALL drive SDA low while SCL is released.
REQ-019 STOP SHALL release SDA while SCL is released.
REQ-020 Consecutive transactions SHALL be separated by at least 4 ticks of bus idle (SCL and SDA both released).
REQ-021 During each ACK bit, SDA SHALL be released and sampled at phase 2; sampled 1 is a NACK.
REQ-022 On a NACK, the block SHALL issue STOP and then retry the same entry from START.
REQ-023 After MAX_RETRY failed retries, the block SHALL enter ERROR: CONFIG_ERROR=1, bus released, and it stays there until reset.
REQ-024 FSM states SHALL be: POWERUP, IDLE_GAP, START, SEND_BYTE, ACK, STOP, NEXT, DONE, ERROR.
- NEXT increments the entry index; at N it goes to DONE.
REQ-025 In DONE: CONFIG_DONE=1, I2C_SCL_OE=0, I2C_SDA_OE=0.
REQ-026 A falling edge on HDMI_TX_INT (synchronized through 2 flops) in DONE SHALL clear CONFIG_DONE and restart at entry 0 without the power-up wait.
- Hot-plug resets the ADV7513 registers, so the full table is rewritten.
REQ-027 HDMI_TX_INT edges outside DONE SHALL be ignored.
REQ-028 The retry counter SHALL clear on every successful entry.
- Its width is clog2(MAX_RETRY+1).

Reset
REQ-029 Reset values SHALL be:
- I2C_SCL_OE=0, I2C_SDA_OE=0, CONFIG_DONE=0, CONFIG_ERROR=0;
- state=POWERUP; entry index, bit, tick and retry counters all 0.
REQ-030 A reset asserted mid-transaction SHALL release both lines on the next clock edge.
- No STOP is generated.
- The sequence restarts from POWERUP.

Structure
REQ-031 A shared package SHALL hold:
- the FSM state enum;
- the entry type {reg[7:0], data[7:0]};
- N = 12;
- the init table, in this order: 41=10, 98=03, 9A=E0, 9C=30, 9D=61, A2=A4, A3=A4, E0=D0, F9=00, 15=00, 16=30, AF=04.
REQ-032 Sub-module hdmi_cfg_rom SHALL map the entry index to an entry combinationally from the package table.

Verification
REQ-033 The bench SHALL run with CLK_DIV=4, POWERUP_CYCLES=16 and an always-ACK slave model. Required: 12 transactions decode as 72/41/10 ... 72/AF/04, then CONFIG_DONE=1 and both OE=0.
REQ-034 The slave SHALL NACK the data byte of entry 3 once. Required: a STOP, then entry 3 (72/9C/30) is resent, and CONFIG_DONE=1 after 13 transactions in total.
REQ-035 The slave SHALL NACK the address byte 4 times. Required: 4 attempts, then CONFIG_ERROR=1, CONFIG_DONE=0, and the bus stays released.
REQ-036 After DONE, the bench SHALL pulse HDMI_TX_INT low for 1 cycle. Required: CONFIG_DONE falls within 4 cycles, then the table is rewritten from 72/41/10 with no power-up delay.
REQ-037 The bench SHALL assert RESET during bit 5 of entry 2. Required: both OE=0 on the next edge, and the first START appears 16 cycles after reset is released.
